ddr_step_judge_ctrl: RTL and testbench

//  Game sequencer and judge for the DDR arrow lanes. Produces the one-cycle step pulse

---
 rtl/ddr_step_judge_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_ddr_step_judge_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_step_judge_ctrl.sv
// ddr_step_judge_ctrl
// Game sequencer and judge for the DDR arrow lanes. It divides the system clock
// down to the lane step rate, counts out the countdown while the first notes
// travel down the lanes, and then judges the hit row against the player's
// presses on every step. The judge results drive the combo and lives counters
// and the IDLE/COUNTDOWN/PLAY/OVER game state.
module ddr_step_judge_ctrl #(
  parameter int LANES      = 4,
  parameter int LANE_DEPTH = 8,
  parameter int STEP_DIV   = 12500000,
  parameter int LIVES      = 3,
  parameter int COMBO_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [LANES-1:0]   btn,
  input  logic [LANES-1:0]   hit_row,
  output logic               step,
  output logic               spawn_en,
  output logic               judge_valid,
  output logic [2:0]         hit_cnt,
  output logic [2:0]         miss_cnt,
  output logic [COMBO_W-1:0] combo,
  output logic [2:0]         lives,
  output logic [1:0]         state,
  output logic               game_over
);

  localparam int DIV_W      = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam int STEP_CNT_W = $clog2(LANE_DEPTH + 1);
  localparam int SUM_W      = ((COMBO_W > 3) ? COMBO_W : 3) + 1;

  localparam logic [DIV_W-1:0]      DIV_LAST   = DIV_W'(STEP_DIV - 1);
  localparam logic [STEP_CNT_W-1:0] CD_LAST    = STEP_CNT_W'(LANE_DEPTH - 1);
  localparam logic [COMBO_W-1:0]    COMBO_MAX  = '1;
  localparam logic [2:0]            LIVES_INIT = 3'(LIVES);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_COUNTDOWN = 2'd1,
    S_PLAY      = 2'd2,
    S_OVER      = 2'd3
  } state_t;

  state_t                st_q;
  logic [DIV_W-1:0]      div_q;
  logic [STEP_CNT_W-1:0] step_cnt_q;
  logic [LANES-1:0]      press_q;
  logic [COMBO_W-1:0]    combo_q;
  logic [2:0]            lives_q;

  logic                  judge_vld_p1;
  logic [2:0]            hit_cnt_p1;
  logic [2:0]            miss_cnt_p1;

  logic                  running;
  logic                  step_p0;
  logic                  judge_p0;
  logic [LANES-1:0]      press_all_p0;
  logic [LANES-1:0]      hit_vec_p0;
  logic [LANES-1:0]      miss_vec_p0;
  logic [LANES-1:0]      false_vec_p0;
  logic [2:0]            hit_n_p0;
  logic [2:0]            miss_n_p0;
  logic [2:0]            lives_dec_p0;

  // Number of set bits in a lane vector; LANES never exceeds what fits in 3 bits.
  function automatic logic [2:0] popcount(input logic [LANES-1:0] v);
    logic [2:0] cnt;
    cnt = 3'd0;
    for (int i = 0; i < LANES; i++) begin
      cnt = cnt + 3'(v[i]);
    end
    return cnt;
  endfunction

  // Combo increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [COMBO_W-1:0] sat_add(input logic [COMBO_W-1:0] a,
                                                 input logic [2:0]         b);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(a) + SUM_W'(b);
    if (sum > SUM_W'(COMBO_MAX)) begin
      return COMBO_MAX;
    end
    return COMBO_W'(sum);
  endfunction

  // Life decrement that never goes below zero.
  function automatic logic [2:0] sat_dec(input logic [2:0] v);
    return (v == 3'd0) ? 3'd0 : (v - 3'd1);
  endfunction

  // ---- stage p0: step timing and combinational judge of the pre-shift hit row
  always_comb begin
    running      = (st_q == S_COUNTDOWN) || (st_q == S_PLAY);
    step_p0      = running && (div_q == DIV_LAST);
    judge_p0     = (st_q == S_PLAY) && step_p0;
    // A press arriving in the step cycle itself still counts for this step.
    press_all_p0 = press_q | btn;
    hit_vec_p0   = hit_row & press_all_p0;
    miss_vec_p0  = hit_row & ~press_all_p0;
    false_vec_p0 = press_all_p0 & ~hit_row;
    hit_n_p0     = popcount(hit_vec_p0);
    miss_n_p0    = popcount(miss_vec_p0) + popcount(false_vec_p0);
    lives_dec_p0 = sat_dec(lives_q);
  end

  // Step divider: free-runs only while a game is in progress, idles at zero otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q <= '0;
    end else if (running) begin
      div_q <= step_p0 ? '0 : (div_q + DIV_W'(1));
    end else begin
      div_q <= '0;
    end
  end

  // Press accumulator: collects presses between steps in PLAY, emptied by each step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      press_q <= '0;
    end else if ((st_q == S_PLAY) && !step_p0) begin
      press_q <= press_q | btn;
    end else begin
      press_q <= '0;
    end
  end

  // ---- stage p1: registered judge results, held until the next judged step
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      judge_vld_p1 <= 1'b0;
      hit_cnt_p1   <= 3'd0;
      miss_cnt_p1  <= 3'd0;
    end else begin
      judge_vld_p1 <= judge_p0;
      if (judge_p0) begin
        hit_cnt_p1  <= hit_n_p0;
        miss_cnt_p1 <= miss_n_p0;
      end
    end
  end

  // Game FSM with countdown step counter, combo and lives; they change together with the judge pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q       <= S_IDLE;
      step_cnt_q <= '0;
      combo_q    <= '0;
      lives_q    <= 3'd0;
    end else begin
      case (st_q)
        S_IDLE, S_OVER: begin
          if (start) begin
            st_q       <= S_COUNTDOWN;
            step_cnt_q <= '0;
            combo_q    <= '0;
            lives_q    <= LIVES_INIT;
          end
        end
        S_COUNTDOWN: begin
          if (step_p0) begin
            if (step_cnt_q == CD_LAST) begin
              st_q       <= S_PLAY;
              step_cnt_q <= '0;
            end else begin
              step_cnt_q <= step_cnt_q + STEP_CNT_W'(1);
            end
          end
        end
        S_PLAY: begin
          if (judge_p0) begin
            if (miss_n_p0 != 3'd0) begin
              combo_q <= '0;
              lives_q <= lives_dec_p0;
              if (lives_dec_p0 == 3'd0) begin
                st_q <= S_OVER;
              end
            end else begin
              combo_q <= sat_add(combo_q, hit_n_p0);
            end
          end
        end
        default: begin
          st_q <= S_IDLE;
        end
      endcase
    end
  end

  assign step        = step_p0;
  assign spawn_en    = running;
  assign judge_valid = judge_vld_p1;
  assign hit_cnt     = hit_cnt_p1;
  assign miss_cnt    = miss_cnt_p1;
  assign combo       = combo_q;
  assign lives       = lives_q;
  assign state       = st_q;
  assign game_over   = (st_q == S_OVER);

endmodule

// File: tb/tb_ddr_step_judge_ctrl.sv
// Bench for ddr_step_judge_ctrl: short step period and countdown, 2-bit combo
// so saturation is reachable. Expected judge results are queued in the step
// cycle and compared when judge_valid appears.
module tb_ddr_step_judge_ctrl;

  localparam int LANES      = 4;
  localparam int LANE_DEPTH = 2;
  localparam int STEP_DIV   = 4;
  localparam int LIVES      = 3;
  localparam int COMBO_W    = 2;

  logic               clk;
  logic               reset;
  logic               start;
  logic [LANES-1:0]   btn;
  logic [LANES-1:0]   hit_row;
  logic               step;
  logic               spawn_en;
  logic               judge_valid;
  logic [2:0]         hit_cnt;
  logic [2:0]         miss_cnt;
  logic [COMBO_W-1:0] combo;
  logic [2:0]         lives;
  logic [1:0]         state;
  logic               game_over;

  typedef struct packed {
    logic [2:0]         h;
    logic [2:0]         m;
    logic [COMBO_W-1:0] c;
    logic [2:0]         l;
  } exp_t;

  exp_t sb[$];
  int   total;
  int   bad;
  int   exp_combo;
  int   exp_lives;

  ddr_step_judge_ctrl #(
    .LANES(LANES), .LANE_DEPTH(LANE_DEPTH), .STEP_DIV(STEP_DIV),
    .LIVES(LIVES), .COMBO_W(COMBO_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .btn(btn), .hit_row(hit_row),
    .step(step), .spawn_en(spawn_en), .judge_valid(judge_valid),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .combo(combo), .lives(lives),
    .state(state), .game_over(game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock, sample 1 time unit after the edge, service the scoreboard.
  task automatic cycle();
    exp_t e;
    @(posedge clk);
    #1;
    if (judge_valid) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_judge: judge_valid=1 required=0 state=%0d", state);
      end else begin
        e = sb.pop_front();
        if ({hit_cnt, miss_cnt, combo, lives} !== {e.h, e.m, e.c, e.l}) begin
          bad++;
          $display("FAIL judge_result: hit=%0d miss=%0d combo=%0d lives=%0d required hit=%0d miss=%0d combo=%0d lives=%0d",
                   hit_cnt, miss_cnt, combo, lives, e.h, e.m, e.c, e.l);
        end
      end
    end else if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL missing_judge: judge_valid=0 required=1");
      sb.delete();
    end
  endtask

  // Queue the judge outcome for a step with note row n and combined presses p.
  task automatic push_expect(input logic [LANES-1:0] n, input logic [LANES-1:0] p);
    exp_t e;
    int   h;
    int   m;
    h = $countones(n & p);
    m = $countones(n & ~p) + $countones(p & ~n);
    if (m != 0) begin
      exp_combo = 0;
      if (exp_lives > 0) exp_lives--;
    end else begin
      exp_combo = (exp_combo + h > 3) ? 3 : exp_combo + h;
    end
    e.h = 3'(h);
    e.m = 3'(m);
    e.c = COMBO_W'(exp_combo);
    e.l = 3'(exp_lives);
    sb.push_back(e);
  endtask

  // Advance at least one cycle and stop in the next cycle that shows step=1.
  task automatic goto_step();
    int n;
    n = 0;
    cycle();
    while (!step && n < 20) begin
      cycle();
      n++;
    end
    total++;
    if (!step) begin
      bad++;
      $display("FAIL step_timeout: step=%0d required=1", step);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({step, spawn_en, judge_valid, hit_cnt, miss_cnt, combo, lives, game_over} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: step=%0d spawn=%0d jv=%0d hit=%0d miss=%0d combo=%0d lives=%0d over=%0d required all 0",
               step, spawn_en, judge_valid, hit_cnt, miss_cnt, combo, lives, game_over);
    end
    total++;
    if (state !== 2'd0) begin
      bad++;
      $display("FAIL reset_state: state=%0d required=0", state);
    end
    reset = 1'b1;
    cycle();
  endtask

  task automatic test_countdown();
    logic       exp_step;
    logic [1:0] exp_st;
    start = 1'b1;
    cycle();
    start = 1'b0;
    exp_combo = 0;
    exp_lives = LIVES;
    total++;
    if (spawn_en !== 1'b1 || lives !== 3'd3 || combo !== '0) begin
      bad++;
      $display("FAIL countdown_init: spawn=%0d lives=%0d combo=%0d required spawn=1 lives=3 combo=0",
               spawn_en, lives, combo);
    end
    for (int n = 1; n <= 12; n++) begin
      exp_step = (n == 4) || (n == 8) || (n == 12);
      exp_st   = (n >= 9) ? 2'd2 : 2'd1;
      total++;
      if (step !== exp_step) begin
        bad++;
        $display("FAIL countdown_step: cycle=%0d step=%0d required=%0d", n, step, exp_step);
      end
      total++;
      if (state !== exp_st) begin
        bad++;
        $display("FAIL countdown_state: cycle=%0d state=%0d required=%0d", n, state, exp_st);
      end
      if (n == 12) push_expect(4'b0000, 4'b0000);
      cycle();
    end
  endtask

  task automatic test_hit();
    cycle();
    btn = 4'b1010;
    cycle();
    btn = 4'b0000;
    cycle();
    total++;
    if (step !== 1'b1) begin
      bad++;
      $display("FAIL hit_step_align: step=%0d required=1", step);
    end
    hit_row = 4'b1010;
    push_expect(4'b1010, 4'b1010);
    cycle();
    hit_row = 4'b0000;
    total++;
    if (combo !== 2'd2 || lives !== 3'd3) begin
      bad++;
      $display("FAIL hit_combo_lives: combo=%0d lives=%0d required combo=2 lives=3", combo, lives);
    end
  endtask

  task automatic test_miss();
    repeat (3) cycle();
    total++;
    if (step !== 1'b1) begin
      bad++;
      $display("FAIL miss_step_align: step=%0d required=1", step);
    end
    hit_row = 4'b0001;
    btn     = 4'b0100;
    push_expect(4'b0001, 4'b0100);
    cycle();
    btn     = 4'b0000;
    hit_row = 4'b0000;
    total++;
    if (miss_cnt !== 3'd2 || lives !== 3'd2 || combo !== '0) begin
      bad++;
      $display("FAIL miss_counts: miss=%0d lives=%0d combo=%0d required miss=2 lives=2 combo=0",
               miss_cnt, lives, combo);
    end
  endtask

  task automatic test_over();
    logic saw_step;
    start = 1'b1;
    cycle();
    start = 1'b0;
    total++;
    if (state !== 2'd2) begin
      bad++;
      $display("FAIL start_in_play: state=%0d required=2", state);
    end
    goto_step();
    hit_row = 4'b1000;
    push_expect(4'b1000, 4'b0000);
    cycle();
    hit_row = 4'b0000;
    goto_step();
    btn = 4'b0010;
    push_expect(4'b0000, 4'b0010);
    cycle();
    btn = 4'b0000;
    total++;
    if (state !== 2'd3 || game_over !== 1'b1 || lives !== 3'd0 || spawn_en !== 1'b0) begin
      bad++;
      $display("FAIL over_entry: state=%0d over=%0d lives=%0d spawn=%0d required state=3 over=1 lives=0 spawn=0",
               state, game_over, lives, spawn_en);
    end
    saw_step = 1'b0;
    for (int i = 0; i < 12; i++) begin
      btn = (i % 3 == 0) ? 4'b1111 : 4'b0000;
      hit_row = 4'b0101;
      if (step) saw_step = 1'b1;
      cycle();
    end
    btn = 4'b0000;
    hit_row = 4'b0000;
    total++;
    if (saw_step !== 1'b0 || state !== 2'd3) begin
      bad++;
      $display("FAIL over_hold: saw_step=%0d state=%0d required saw_step=0 state=3", saw_step, state);
    end
    start = 1'b1;
    cycle();
    start = 1'b0;
    exp_combo = 0;
    exp_lives = LIVES;
    total++;
    if (state !== 2'd1 || lives !== 3'd3 || combo !== '0 || game_over !== 1'b0) begin
      bad++;
      $display("FAIL restart: state=%0d lives=%0d combo=%0d over=%0d required state=1 lives=3 combo=0 over=0",
               state, lives, combo, game_over);
    end
  endtask

  task automatic test_combo_sat();
    logic [COMBO_W-1:0] seq [4];
    seq[0] = 2'd1;
    seq[1] = 2'd2;
    seq[2] = 2'd3;
    seq[3] = 2'd3;
    btn = 4'b1111;
    cycle();
    btn = 4'b0000;
    goto_step();
    goto_step();
    for (int i = 0; i < 4; i++) begin
      goto_step();
      total++;
      if (state !== 2'd2) begin
        bad++;
        $display("FAIL combo_state: step=%0d state=%0d required=2", i, state);
      end
      hit_row = 4'b0001;
      btn     = 4'b0001;
      push_expect(4'b0001, 4'b0001);
      cycle();
      btn     = 4'b0000;
      hit_row = 4'b0000;
      total++;
      if (combo !== seq[i]) begin
        bad++;
        $display("FAIL combo_sat: step=%0d combo=%0d required=%0d", i, combo, seq[i]);
      end
    end
  endtask

  task automatic test_reset_midgame();
    cycle();
    btn = 4'b1001;
    cycle();
    btn = 4'b0000;
    #2;
    reset = 1'b0;
    #1;
    total++;
    if ({step, spawn_en, judge_valid, hit_cnt, miss_cnt, combo, lives, game_over, state} !== '0) begin
      bad++;
      $display("FAIL midgame_reset: step=%0d spawn=%0d jv=%0d hit=%0d miss=%0d combo=%0d lives=%0d over=%0d state=%0d required all 0",
               step, spawn_en, judge_valid, hit_cnt, miss_cnt, combo, lives, game_over, state);
    end
    repeat (2) cycle();
    reset = 1'b1;
    hit_row = 4'b1111;
    repeat (8) cycle();
    hit_row = 4'b0000;
    total++;
    if (state !== 2'd0 || step !== 1'b0) begin
      bad++;
      $display("FAIL after_reset_idle: state=%0d step=%0d required state=0 step=0", state, step);
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    exp_combo = 0;
    exp_lives = 0;
    reset     = 1'b0;
    start     = 1'b0;
    btn       = '0;
    hit_row   = '0;
    test_reset();
    test_countdown();
    test_hit();
    test_miss();
    test_over();
    test_combo_sat();
    test_reset_midgame();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: pending=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
